edge_burst_sched: RTL and testbench

//  Sequences line-by-line SDRAM traffic for the edge-detection accelerator in mysystem.
//  HPS software sets the source base, destination base and line count, then pulses start through the startsig PIO.
//  Per line, the block issues one Avalon-MM read burst and streams the pixels to the Sobel datapath.
//  It buffers the datapath results and writes them back with one write burst, then raises done for the donesig PIO.

---
 rtl/edge_burst_sched_if.sv | 37 +++
 rtl/edge_burst_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_edge_burst_sched.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_burst_sched_if.sv
// Avalon-MM burst master bus plus the Sobel pixel streams of edge_burst_sched.
// The master modport is the scheduler side; the slave modport is the SDRAM/datapath side.
interface edge_burst_sched_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int BURST_W = 7
);
  logic [ADDR_W-1:0]  avm_address;
  logic [BURST_W-1:0] avm_burstcount;
  logic               avm_read;
  logic               avm_write;
  logic [DATA_W-1:0]  avm_writedata;
  logic               avm_waitrequest;
  logic [DATA_W-1:0]  avm_readdata;
  logic               avm_readdatavalid;
  logic [DATA_W-1:0]  pix_out_data;
  logic               pix_out_valid;
  logic [DATA_W-1:0]  pix_in_data;
  logic               pix_in_valid;
  logic               pix_in_ready;

  modport master (
    output avm_address, avm_burstcount, avm_read, avm_write, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output pix_out_data, pix_out_valid,
    input  pix_in_data, pix_in_valid,
    output pix_in_ready
  );

  modport slave (
    input  avm_address, avm_burstcount, avm_read, avm_write, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  pix_out_data, pix_out_valid,
    output pix_in_data, pix_in_valid,
    input  pix_in_ready
  );
endinterface

// File: rtl/edge_burst_sched.sv
// Line-by-line SDRAM burst scheduler for the edge-detection accelerator: one read burst per
// line streamed to the Sobel datapath, results buffered in a FIFO and written back as one burst.
module edge_burst_sched #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 64,
  parameter int BURST_W   = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [15:0]       num_lines,
  output logic              busy,
  output logic              done,
  output logic [3:0]        status,
  edge_burst_sched_if.master bus
);

  localparam int DEPTH = 2 * BURST_LEN;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0]  STRIDE    = ADDR_W'(BURST_LEN * DATA_W / 8);
  localparam logic [BURST_W-1:0] BURST_CNT = BURST_W'(BURST_LEN);
  localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]   FIFO_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   FIFO_LINE = CNT_W'(BURST_LEN);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RD_REQ   = 4'd1,
    RD_DATA  = 4'd2,
    WR_WAIT  = 4'd3,
    WR_BURST = 4'd4,
    NEXT     = 4'd5,
    DONE     = 4'd6
  } state_e;

  state_e             state_q, state_d;
  logic               start_dly_q;
  logic [ADDR_W-1:0]  src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0]  dst_ptr_q, dst_ptr_d;
  logic [15:0]        lines_left_q, lines_left_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               avm_read_q, avm_read_d;
  logic               avm_write_q, avm_write_d;
  logic [ADDR_W-1:0]  avm_address_q, avm_address_d;
  logic [BURST_W-1:0] avm_burstcount_q, avm_burstcount_d;
  logic [DATA_W-1:0]  pix_out_data_q, pix_out_data_d;
  logic               pix_out_valid_q, pix_out_valid_d;
  logic               pix_in_ready_q, pix_in_ready_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [DATA_W-1:0]  fifo_mem [DEPTH];

  logic start_edge_s;
  logic push_s;
  logic pop_s;

  assign start_edge_s = start & ~start_dly_q;
  assign push_s       = bus.pix_in_valid & pix_in_ready_q;
  assign pop_s        = avm_write_q & ~bus.avm_waitrequest;

  // Next-state, pointer/counter and registered-output computation.
  always_comb begin
    state_d         = state_q;
    src_ptr_d       = src_ptr_q;
    dst_ptr_d       = dst_ptr_q;
    lines_left_d    = lines_left_q;
    beat_cnt_d      = beat_cnt_q;
    busy_d          = busy_q;
    done_d          = done_q;
    pix_out_data_d  = pix_out_data_q;
    pix_out_valid_d = 1'b0;

    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    pix_in_ready_d = (fifo_cnt_d < FIFO_FULL);

    case (state_q)
      IDLE: begin
        if (start_edge_s) begin
          src_ptr_d    = src_base;
          dst_ptr_d    = dst_base;
          lines_left_d = num_lines;
          done_d       = 1'b0;
          busy_d       = 1'b1;
          state_d      = (num_lines == 16'd0) ? DONE : RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (!bus.avm_waitrequest) begin
          beat_cnt_d = '0;
          state_d    = RD_DATA;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_DATA: begin
        if (bus.avm_readdatavalid) begin
          pix_out_data_d  = bus.avm_readdata;
          pix_out_valid_d = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = WR_WAIT;
          end else begin
            beat_cnt_d = beat_cnt_q + BURST_W'(1);
          end
        end else begin
          state_d = RD_DATA;
        end
      end
      WR_WAIT: begin
        if (fifo_cnt_q >= FIFO_LINE) begin
          state_d = WR_BURST;
        end else begin
          state_d = WR_WAIT;
        end
      end
      WR_BURST: begin
        if (pop_s) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = NEXT;
          end else begin
            beat_cnt_d = beat_cnt_q + BURST_W'(1);
          end
        end else begin
          state_d = WR_BURST;
        end
      end
      NEXT: begin
        src_ptr_d    = src_ptr_q + STRIDE;
        dst_ptr_d    = dst_ptr_q + STRIDE;
        lines_left_d = lines_left_q - 16'd1;
        state_d      = (lines_left_q == 16'd1) ? DONE : RD_REQ;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus outputs are registered, so they are derived from where the FSM is heading.
    avm_read_d  = (state_d == RD_REQ);
    avm_write_d = (state_d == WR_BURST);
    if (state_d == RD_REQ) begin
      avm_address_d = src_ptr_d;
    end else if (state_d == WR_BURST) begin
      avm_address_d = dst_ptr_d;
    end else begin
      avm_address_d = '0;
    end
    avm_burstcount_d = (avm_read_d || avm_write_d) ? BURST_CNT : '0;
  end

  // State, pointers, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      start_dly_q      <= 1'b0;
      src_ptr_q        <= '0;
      dst_ptr_q        <= '0;
      lines_left_q     <= '0;
      beat_cnt_q       <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      avm_read_q       <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_address_q    <= '0;
      avm_burstcount_q <= '0;
      pix_out_data_q   <= '0;
      pix_out_valid_q  <= 1'b0;
      pix_in_ready_q   <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      fifo_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      start_dly_q      <= start;
      src_ptr_q        <= src_ptr_d;
      dst_ptr_q        <= dst_ptr_d;
      lines_left_q     <= lines_left_d;
      beat_cnt_q       <= beat_cnt_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      avm_read_q       <= avm_read_d;
      avm_write_q      <= avm_write_d;
      avm_address_q    <= avm_address_d;
      avm_burstcount_q <= avm_burstcount_d;
      pix_out_data_q   <= pix_out_data_d;
      pix_out_valid_q  <= pix_out_valid_d;
      pix_in_ready_q   <= pix_in_ready_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      fifo_cnt_q       <= fifo_cnt_d;
    end
  end

  // Result FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem[wr_ptr_q] <= bus.pix_in_data;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign status             = state_q;
  assign bus.avm_read       = avm_read_q;
  assign bus.avm_write      = avm_write_q;
  assign bus.avm_address    = avm_address_q;
  assign bus.avm_burstcount = avm_burstcount_q;
  assign bus.avm_writedata  = avm_write_q ? fifo_mem[rd_ptr_q] : '0;
  assign bus.pix_out_data   = pix_out_data_q;
  assign bus.pix_out_valid  = pix_out_valid_q;
  assign bus.pix_in_ready   = pix_in_ready_q;

endmodule

// File: tb/tb_edge_burst_sched.sv
// Self-checking bench for edge_burst_sched: SDRAM slave and echo datapath modelled with queues,
// write-back data predicted from a queue of every result offered to the FIFO.
module tb_edge_burst_sched;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 4;
  localparam int BURST_W   = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_base = 32'd0;
  logic [31:0] dst_base = 32'd0;
  logic [15:0] num_lines = 16'd0;
  logic        busy;
  logic        done;
  logic [3:0]  status;

  edge_burst_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus_if ();

  edge_burst_sched #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .BURST_W(BURST_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_base(src_base), .dst_base(dst_base), .num_lines(num_lines),
    .busy(busy), .done(done), .status(status),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] rd_pend[$];
  logic [15:0] exp_pix[$];
  logic [15:0] dp_q[$];
  logic [15:0] result_log[$];
  logic [31:0] rd_addr_log[$];
  logic [31:0] wr_addr_log[$];
  logic [15:0] wr_data_log[$];
  int widx = 0;
  int bc_err = 0, both_err = 0, order_err = 0, pix_err = 0, hold_err = 0, rw_seen = 0;
  int rnd_mode = 0;
  bit stall_mode2 = 1'b0;
  int stall_n = 0;
  bit toggled = 1'b0;
  logic [31:0] held_addr;
  logic [15:0] held_data;
  logic [2:0]  held_bc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave memory + echo datapath, evaluated once per cycle just after the rising edge.
  task automatic env();
    logic w;
    logic [15:0] e;
    if (bus_if.avm_read || bus_if.avm_write) rw_seen++;
    if (bus_if.avm_read && bus_if.avm_write) both_err++;
    if (bus_if.pix_out_valid) begin
      if (exp_pix.size() == 0) pix_err++;
      else begin
        e = exp_pix.pop_front();
        if (bus_if.pix_out_data !== e) pix_err++;
        dp_q.push_back(e + 16'd1);
        result_log.push_back(e + 16'd1);
      end
    end
    if (rd_pend.size() > 0 && (rnd_mode == 0 || $urandom_range(0, 3) != 0)) begin
      bus_if.avm_readdatavalid = 1'b1;
      bus_if.avm_readdata = rd_pend.pop_front();
      exp_pix.push_back(bus_if.avm_readdata);
    end else begin
      bus_if.avm_readdatavalid = 1'b0;
      bus_if.avm_readdata = 16'($urandom);
    end
    if (dp_q.size() > 0 && (rnd_mode == 0 || !bus_if.pix_in_ready || $urandom_range(0, 2) != 0)) begin
      bus_if.pix_in_valid = 1'b1;
      bus_if.pix_in_data = dp_q[0];
      if (bus_if.pix_in_ready) dp_q.delete(0);
    end else begin
      bus_if.pix_in_valid = 1'b0;
    end
    w = 1'b0;
    if (rnd_mode != 0) w = ($urandom_range(0, 3) == 0);
    if (stall_mode2 && bus_if.avm_write && wr_addr_log.size() == 1) begin
      if (stall_n == 0) begin
        held_addr = bus_if.avm_address;
        held_data = bus_if.avm_writedata;
        held_bc   = bus_if.avm_burstcount;
      end else if (bus_if.avm_address !== held_addr || bus_if.avm_writedata !== held_data ||
                   bus_if.avm_burstcount !== held_bc) begin
        hold_err++;
      end
      if (stall_n < 3) begin
        w = 1'b1;
        stall_n++;
      end
    end
    bus_if.avm_waitrequest = w;
    if (bus_if.avm_read && !w) begin
      if (wr_addr_log.size() != BURST_LEN * rd_addr_log.size()) order_err++;
      if (bus_if.avm_burstcount !== BURST_W'(BURST_LEN)) bc_err++;
      rd_addr_log.push_back(bus_if.avm_address);
      for (int i = 0; i < BURST_LEN; i++) rd_pend.push_back(16'($urandom));
    end
    if (bus_if.avm_write && !w) begin
      if (bus_if.avm_burstcount !== BURST_W'(BURST_LEN)) bc_err++;
      wr_addr_log.push_back(bus_if.avm_address);
      wr_data_log.push_back(bus_if.avm_writedata);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    env();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_status"}, status, 0);
    chk({tag, "_read"}, bus_if.avm_read, 0);
    chk({tag, "_write"}, bus_if.avm_write, 0);
    chk({tag, "_addr"}, bus_if.avm_address, 0);
    chk({tag, "_bcount"}, bus_if.avm_burstcount, 0);
    chk({tag, "_wdata"}, bus_if.avm_writedata, 0);
    chk({tag, "_pixv"}, bus_if.pix_out_valid, 0);
    chk({tag, "_pixd"}, bus_if.pix_out_data, 0);
    chk({tag, "_ready"}, bus_if.pix_in_ready, 0);
  endtask

  task automatic run_frame(input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] lines, input bit toggle, input string tag);
    int cyc;
    logic [31:0] ea;
    rd_addr_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    stall_n = 0;
    toggled = 1'b0;
    src_base = src; dst_base = dst; num_lines = lines; start = 1'b1;
    step();
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_done_clr"}, done, 0);
    start = 1'b0;
    src_base = $urandom; dst_base = $urandom; num_lines = 16'($urandom_range(1, 5));
    cyc = 0;
    while (!(done && !busy) && cyc < 3000) begin
      if (toggle && !toggled && status == 4'd2) begin
        start = 1'b1;
        toggled = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_finished"}, cyc < 3000, 1);
    chk({tag, "_nreads"}, rd_addr_log.size(), lines);
    chk({tag, "_nwrites"}, wr_addr_log.size(), BURST_LEN * lines);
    for (int i = 0; i < rd_addr_log.size(); i++) begin
      ea = src + 32'(i * BURST_LEN * DATA_W / 8);
      chk({tag, "_rdaddr"}, rd_addr_log[i], ea);
    end
    for (int j = 0; j < wr_addr_log.size(); j++) begin
      ea = dst + 32'((j / BURST_LEN) * BURST_LEN * DATA_W / 8);
      chk({tag, "_wraddr"}, wr_addr_log[j], ea);
      if (widx + j < result_log.size()) chk({tag, "_wrdata"}, wr_data_log[j], result_log[widx + j]);
    end
    widx += wr_data_log.size();
    step();
    chk({tag, "_done_hold"}, done, 1);
    chk({tag, "_idle"}, status, 0);
  endtask

  initial begin
    int cyc;
    bus_if.avm_waitrequest = 1'b0;
    bus_if.avm_readdata = 16'd0;
    bus_if.avm_readdatavalid = 1'b0;
    bus_if.pix_in_data = 16'd0;
    bus_if.pix_in_valid = 1'b0;

    #2 reset_n = 1'b0;
    #1;
    check_all_zero("rst0");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    chk("rel_status", status, 0);
    chk("rel_done", done, 0);
    chk("rel_ready", bus_if.pix_in_ready, 1);

    // Zero lines: busy for one cycle, done right after, no bus traffic.
    rw_seen = 0;
    src_base = 32'h1000; dst_base = 32'h2000; num_lines = 16'd0; start = 1'b1;
    step();
    chk("z_busy", busy, 1);
    chk("z_status", status, 6);
    start = 1'b0;
    step();
    chk("z_done", done, 1);
    chk("z_busy_off", busy, 0);
    step();
    chk("z_done_hold", done, 1);
    chk("z_no_rw", rw_seen, 0);

    // Two lines, no stalls, fixed bases.
    run_frame(32'h1000, 32'h2000, 16'd2, 1'b0, "basic");

    // Three stall cycles on the second write beat.
    stall_mode2 = 1'b1;
    run_frame(32'h3000, 32'h4000, 16'd1, 1'b0, "wstall");
    stall_mode2 = 1'b0;
    chk("wstall_cycles", stall_n, 3);
    chk("wstall_hold", hold_err, 0);

    // Random stalls/gaps, start toggled mid-frame, then address wrap.
    rnd_mode = 1;
    run_frame(32'($urandom) & 32'hFFFF_FFF0, 32'($urandom) & 32'hFFFF_FFF0, 16'd2, 1'b1, "toggle");
    chk("toggle_seen", toggled, 1);
    run_frame(32'hFFFF_FFF0, 32'hFFFF_FFF8, 16'd3, 1'b0, "wrap");

    // Datapath offers ten results while idle: FIFO takes eight and holds off the rest.
    rnd_mode = 0;
    for (int i = 0; i < 10; i++) begin
      dp_q.push_back(16'($urandom));
      result_log.push_back(dp_q[i]);
    end
    repeat (12) step();
    chk("fill_taken", 10 - dp_q.size(), 8);
    chk("fill_ready", bus_if.pix_in_ready, 0);
    rnd_mode = 1;
    run_frame(32'h0000_8000, 32'h0000_9000, 16'd3, 1'b0, "full");
    rnd_mode = 0;

    // Reset in the middle of a read burst.
    src_base = 32'h5000; dst_base = 32'h6000; num_lines = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (status != 4'd2 && cyc < 200) begin
      step();
      cyc++;
    end
    chk("mid_reached", cyc < 200, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    rd_pend.delete(); exp_pix.delete(); dp_q.delete(); result_log.delete();
    widx = 0;
    bus_if.avm_readdatavalid = 1'b0;
    bus_if.pix_in_valid = 1'b0;
    bus_if.avm_waitrequest = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    chk("mid_rel_status", status, 0);
    chk("mid_rel_done", done, 0);
    chk("mid_rel_busy", busy, 0);
    run_frame(32'h0000_0100, 32'h0000_0200, 16'd1, 1'b0, "post");

    chk("never_both", both_err, 0);
    chk("burstcount", bc_err, 0);
    chk("rd_after_wb", order_err, 0);
    chk("pix_out", pix_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
